// File: rtl/line_mem_responder_if.sv
// -----------------------------------------------------------------------------
// line_mem_responder_if
// Request/response bundle between the D-cache miss handler (master) and the
// line memory responder (slave).
//   req_addr_i   byte address of the requested line
//   req_data_i   write-back line data (ignored for reads)
//   req_rw_i     1 = write line, 0 = read line
//   req_valid_i  request valid, held until rsp_ready_o is seen
//   rsp_data_o   response line
//   rsp_ready_o  one-cycle response pulse
// Signal suffixes are given from the responder's point of view.
// -----------------------------------------------------------------------------
interface line_mem_responder_if #(
  parameter int LINE_W = 128
);
  logic [31:0]       req_addr_i;
  logic [LINE_W-1:0] req_data_i;
  logic              req_rw_i;
  logic              req_valid_i;
  logic [LINE_W-1:0] rsp_data_o;
  logic              rsp_ready_o;

  modport master (
    output req_addr_i, req_data_i, req_rw_i, req_valid_i,
    input  rsp_data_o, rsp_ready_o
  );

  modport slave (
    input  req_addr_i, req_data_i, req_rw_i, req_valid_i,
    output rsp_data_o, rsp_ready_o
  );
endinterface

// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
// Backing store behind the D-cache: services line-granular read/write requests
// against an internal line-wide array after a fixed latency and returns the
// line with a one-cycle pulse. Read/write service counters for perf debug.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   bus        request/response bundle (slave side)
//   busy_o     high while a request is outstanding
//   no_rd_o    completed read responses (wraps)
//   no_wr_o    completed write responses (wraps)
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for req_valid_i; request fields latched on accept
// S_WAIT | latency down-counter running, request inputs ignored
// S_RESP | rsp_ready_o high; write commits, service counter bumps
// -----------------------------------------------------------------------------
module line_mem_responder #(
  parameter int LINE_W  = 128,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_mem_responder_if.slave  bus,
  output logic                 busy_o,
  output logic [31:0]          no_rd_o,
  output logic [31:0]          no_wr_o
);

  localparam int OFS  = $clog2(LINE_W / 8);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   idx_d;
  logic [LINE_W-1:0] wdata_q;
  logic              rw_q;
  logic [LINE_W-1:0] rsp_data_q;
  logic              rsp_ready_q;
  logic              busy_q;
  logic [31:0]       no_rd_q;
  logic [31:0]       no_wr_q;

  // Storage is deliberately outside reset: contents survive rst_i.
  logic [LINE_W-1:0] mem [DEPTH];

  // Offset and upper address bits are dropped, so addresses alias modulo DEPTH.
  assign idx_d = bus.req_addr_i[OFS +: IDXW];

  logic [31:0] unused_addr;
  assign unused_addr = bus.req_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      no_rd_q     <= '0;
      no_wr_q     <= '0;
    end else begin
      rsp_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            idx_q   <= idx_d;
            wdata_q <= bus.req_data_i;
            rw_q    <= bus.req_rw_i;
            cnt_q   <= CNTW'(LATENCY - 1);
            busy_q  <= 1'b1;
            if (LATENCY == 1) begin
              // Single-cycle latency skips WAIT and loads the response now.
              state_q     <= S_RESP;
              rsp_ready_q <= 1'b1;
              rsp_data_q  <= bus.req_rw_i ? bus.req_data_i : mem[idx_d];
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == CNTW'(1)) begin
            state_q     <= S_RESP;
            rsp_ready_q <= 1'b1;
            // A write echoes its own data back.
            rsp_data_q  <= rw_q ? wdata_q : mem[idx_q];
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (rw_q) begin
            no_wr_q <= no_wr_q + 32'd1;
          end else begin
            no_rd_q <= no_rd_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write commits at the end of RESP; a reset in that cycle discards it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_RESP && rw_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_ready_o = rsp_ready_q;
  assign busy_o          = busy_q;
  assign no_rd_o         = no_rd_q;
  assign no_wr_o         = no_wr_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_line_mem_responder
// Scoreboard bench for line_mem_responder (LINE_W=128, DEPTH=1024, LATENCY=4).
// The driver pushes the expected response for each request it issues; a
// negedge monitor pops and compares whenever rsp_ready_o pulses.
// -----------------------------------------------------------------------------
module tb_line_mem_responder;

  localparam int LINE_W  = 128;
  localparam int DEPTH   = 1024;
  localparam int LAT     = 4;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hFEDCBA98765432100F1E2D3C4B5A6978;
  localparam logic [127:0] D5 = {16{8'h55}};
  localparam logic [127:0] DA = {16{8'hAA}};
  localparam logic [127:0] DX = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  typedef struct {
    logic         rw;
    logic [127:0] data;
    int           idx;
    int           cyc;
    logic [31:0]  rd0;
    logic [31:0]  wr0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] no_rd;
  logic [31:0] no_wr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t         sb [$];
  logic [127:0] mmem [int];
  logic [31:0]  n_rd_m = 0;
  logic [31:0]  n_wr_m = 0;
  bit           at_pulse = 0;

  line_mem_responder_if #(.LINE_W(LINE_W)) bus ();

  line_mem_responder #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .busy_o (busy),
    .no_rd_o(no_rd),
    .no_wr_o(no_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {127'b0, bus.rsp_ready_o}, 128'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", bus.rsp_data_o, e.data);
        check("rsp_cycle", cyc, e.cyc);
        check("no_rd_before", no_rd, e.rd0);
        check("no_wr_before", no_wr, e.wr0);
        if (e.rw) mmem[e.idx] = e.data;
      end
    end
  end

  // Issue one request from a negedge. With hold=1 valid stays high after the
  // pulse so the next call forms a back-to-back request.
  task automatic issue(input logic [31:0] addr, input logic [127:0] data,
                       input logic rw, input bit hold);
    exp_t e;
    int   idx;
    if (at_pulse) begin
      @(negedge clk);
      check("b2b_idle_busy", busy, 0);
    end
    bus.req_addr_i  = addr;
    bus.req_data_i  = data;
    bus.req_rw_i    = rw;
    bus.req_valid_i = 1'b1;
    idx    = int'((addr >> 4) & 32'h3FF);
    e.rw   = rw;
    e.idx  = idx;
    e.data = rw ? data : mmem[idx];
    e.cyc  = cyc + LAT;
    e.rd0  = n_rd_m;
    e.wr0  = n_wr_m;
    sb.push_back(e);
    if (rw) n_wr_m++;
    else    n_rd_m++;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check("busy_during", busy, 1);
      check("rsp_pulse_timing", bus.rsp_ready_o, (k == LAT));
    end
    if (hold) begin
      at_pulse = 1;
    end else begin
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_ready", bus.rsp_ready_o, 0);
      at_pulse = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idxs [4] = '{0, 4, 8, 16};
    int          idx;
    logic [31:0] addr;
    logic        rw;
    bit          hold;

    // Reset with a valid write pending: reset must win.
    rst             = 1'b1;
    bus.req_addr_i  = 32'h40;
    bus.req_data_i  = DX;
    bus.req_rw_i    = 1'b1;
    bus.req_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.rsp_ready_o, 0);
    rst             = 1'b0;
    bus.req_valid_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready0", bus.rsp_ready_o, 0);
      check("idle_busy0", busy, 0);
      check("idle_rsp_data0", bus.rsp_data_o, 0);
      check("idle_no_rd0", no_rd, 0);
      check("idle_no_wr0", no_wr, 0);
    end

    // Write then read of the same line with a different byte offset.
    issue(32'h0000_0040, D1, 1'b1, 0);
    check("no_wr_after_w", no_wr, 1);
    issue(32'h0000_004C, 128'd0, 1'b0, 0);
    check("no_rd_after_r", no_rd, 1);
    check("rsp_data_holds", bus.rsp_data_o, D1);

    issue(32'h0000_0100, D5, 1'b1, 0);

    // Back-to-back: write-back of 0x80 followed by allocate read of 0x40.
    issue(32'h0000_0080, D2, 1'b1, 1);
    issue(32'h0000_0040, 128'd0, 1'b0, 0);

    // Index aliasing: 0x4000 maps to line 0.
    issue(32'h0000_0000, DA, 1'b1, 0);
    issue(32'h0000_4000, 128'd0, 1'b0, 0);

    // Reset during WAIT of a write to 0x100.
    bus.req_addr_i  = 32'h0000_0100;
    bus.req_data_i  = DX;
    bus.req_rw_i    = 1'b1;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    check("abort_busy_accept", busy, 1);
    @(negedge clk);
    check("abort_busy_wait", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_drop", busy, 0);
    check("abort_ready", bus.rsp_ready_o, 0);
    check("abort_no_rd", no_rd, 0);
    check("abort_no_wr", no_wr, 0);
    rst             = 1'b0;
    bus.req_valid_i = 1'b0;
    n_rd_m          = 0;
    n_wr_m          = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_pulse", bus.rsp_ready_o, 0);
    end
    issue(32'h0000_0100, 128'd0, 1'b0, 0);
    check("abort_rd_count", no_rd, 1);

    // Random mix over known lines, random offsets and aliasing upper bits.
    for (int k = 0; k < 16; k++) begin
      idx  = idxs[$urandom_range(0, 3)];
      addr = ($urandom() & 32'hFFFF_C00F) | (idx << 4);
      rw   = 1'($urandom_range(0, 1));
      hold = (k != 15) && ($urandom_range(0, 1) == 1);
      issue(addr, {$urandom(), $urandom(), $urandom(), $urandom()}, rw, hold);
    end

    repeat (3) @(negedge clk);
    check("final_no_rd", no_rd, n_rd_m);
    check("final_no_wr", no_wr, n_wr_m);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
